// File: rtl/psum_accumulator_pkg.sv
// Shared definitions for the partial-sum accumulator.
//   LANES    : lanes per row (matches the ppu vector width)
//   PSUM_W   : signed partial-sum width per lane
//   DEPTH    : rows per output block
//   ROW_W    : row counter width, clog2(DEPTH)
//   KT_W     : width of the K-tile count
//   PSUM_MAX / PSUM_MIN : saturation bounds for a PSUM_W-bit signed lane
//   state_e  : accumulator control states
package psum_accumulator_pkg;

  localparam int unsigned LANES  = 16;
  localparam int unsigned PSUM_W = 24;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ROW_W  = 4;
  localparam int unsigned KT_W   = 8;

  localparam logic [PSUM_W-1:0] PSUM_MAX = 24'h7FFFFF;
  localparam logic [PSUM_W-1:0] PSUM_MIN = 24'h800000;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/psum_sat_add.sv
// Combinational signed saturating adder for one lane.
//   a, b : W-bit signed operands
//   y    : a + b clamped to the W-bit signed range (never wraps)
module psum_sat_add
  import psum_accumulator_pkg::*;
#(
  parameter int unsigned W = PSUM_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  logic [W:0] sum;

  always_comb begin
    sum = {a[W-1], a} + {b[W-1], b};
    // Overflow when the extended sign differs from the result sign; the
    // extended sign tells which rail to clamp to.
    if (sum[W] != sum[W-1]) begin
      y = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      y = sum[W-1:0];
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator feeding the ppu.
// Collects LANES-wide signed partial-sum rows from the PE array, one row per
// beat, accumulates them over K tiles into a DEPTH-row buffer with saturating
// adds, then drains the finished rows in order on a valid/ready handshake.
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : begin a new block (IDLE only)
//   cfg_k_tiles  : K-tile count, sampled on accepted start (0 means 1)
//   in_valid/in_ready/in_data    : input row handshake
//   out_valid/out_ready/out_data : output row handshake to the ppu
//   busy         : high outside IDLE
//   done         : one-cycle pulse after the last row has drained
module psum_accumulator
  import psum_accumulator_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [KT_W-1:0]         cfg_k_tiles,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*PSUM_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*PSUM_W-1:0] out_data,
  output logic                    busy,
  output logic                    done
);

  state_e                    state_q, state_d;
  logic [ROW_W-1:0]          row_cnt_q, row_cnt_d;
  logic [KT_W-1:0]           tile_cnt_q, tile_cnt_d;
  logic [KT_W-1:0]           k_tiles_q, k_tiles_d;
  logic [ROW_W-1:0]          drain_ptr_q, drain_ptr_d;
  logic                      out_valid_q, out_valid_d;
  logic [LANES*PSUM_W-1:0]   out_data_q, out_data_d;
  logic [LANES*PSUM_W-1:0]   buf_q [DEPTH];
  logic [LANES*PSUM_W-1:0]   buf_d [DEPTH];

  logic [LANES*PSUM_W-1:0]   acc_row;
  logic [LANES*PSUM_W-1:0]   sat_row;
  logic [LANES*PSUM_W-1:0]   wr_row;
  logic                      last_row;
  logic                      last_tile;

  assign acc_row = buf_q[row_cnt_q];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    psum_sat_add #(.W(PSUM_W)) u_sat_add (
      .a (acc_row[i*PSUM_W +: PSUM_W]),
      .b (in_data[i*PSUM_W +: PSUM_W]),
      .y (sat_row[i*PSUM_W +: PSUM_W])
    );
  end

  // First tile overwrites, so stale contents after an aborted block never leak.
  assign wr_row    = (tile_cnt_q == '0) ? in_data : sat_row;
  assign last_row  = (row_cnt_q == ROW_W'(DEPTH - 1));
  assign last_tile = (tile_cnt_q == k_tiles_q - KT_W'(1));

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    tile_cnt_d  = tile_cnt_q;
    k_tiles_d   = k_tiles_q;
    drain_ptr_d = drain_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    buf_d       = buf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          k_tiles_d  = (cfg_k_tiles == '0) ? KT_W'(1) : cfg_k_tiles;
          row_cnt_d  = '0;
          tile_cnt_d = '0;
          state_d    = ACCUM;
        end
      end

      ACCUM: begin
        if (in_valid) begin
          buf_d[row_cnt_q] = wr_row;
          if (last_row) begin
            row_cnt_d = '0;
            if (last_tile) begin
              // buf_d[0] rather than buf_q[0] keeps this correct even when
              // the final write lands on row 0.
              out_data_d  = buf_d[0];
              out_valid_d = 1'b1;
              drain_ptr_d = '0;
              state_d     = DRAIN;
            end else begin
              tile_cnt_d = tile_cnt_q + KT_W'(1);
            end
          end else begin
            row_cnt_d = row_cnt_q + ROW_W'(1);
          end
        end
      end

      DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (drain_ptr_q == ROW_W'(DEPTH - 1)) begin
            out_valid_d = 1'b0;
            state_d     = DONE;
          end else begin
            drain_ptr_d = drain_ptr_q + ROW_W'(1);
            out_data_d  = buf_q[drain_ptr_q + ROW_W'(1)];
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      tile_cnt_q  <= '0;
      k_tiles_q   <= KT_W'(1);
      drain_ptr_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      tile_cnt_q  <= tile_cnt_d;
      k_tiles_q   <= k_tiles_d;
      drain_ptr_q <= drain_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Row storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
